// File: rtl/fp_pkg.sv
// Shared floating-point constants, FSM state type and IEEE-754 single-precision
// field helpers for the multiply path.
//   fp_exp   : biased exponent field
//   fp_frac  : fraction field
//   fp_sign  : sign bit
//   fp_hidden: implicit leading bit (0 for zero/denormal, which are flushed)
//   fp_mant  : full significand {hidden, frac}
package fp_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_FRAC_W = 23;
    localparam int FP_MANT_W = 24;
    localparam int FP_PROD_W = 51;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [31:0] x);
        return FP_EXP_W'(x >> FP_FRAC_W);
    endfunction

    function automatic logic [FP_FRAC_W-1:0] fp_frac(input logic [31:0] x);
        return FP_FRAC_W'(x);
    endfunction

    function automatic logic fp_sign(input logic [31:0] x);
        return 1'(x >> 31);
    endfunction

    function automatic logic fp_hidden(input logic [31:0] x);
        return fp_exp(x) != '0;
    endfunction

    function automatic logic [FP_MANT_W-1:0] fp_mant(input logic [31:0] x);
        return {fp_hidden(x), fp_frac(x)};
    endfunction

endpackage

// File: rtl/fp_mul_mant_seq_if.sv
// Request/result bundle of the sequential significand multiplier.
//   start        : request, sampled only while idle
//   a, b         : IEEE-754 single-precision operands
//   busy         : multiplication in progress
//   done         : one-cycle pulse, result fields valid
//   product      : {1'b0, ma*mb, 2'b00}
//   new_exponent : ea+eb-bias, clamped at 0
//   new_sign     : sign(a) ^ sign(b)
interface fp_mul_mant_seq_if;
    import fp_pkg::*;

    logic                  start;
    logic [31:0]           a;
    logic [31:0]           b;
    logic                  busy;
    logic                  done;
    logic [FP_PROD_W-1:0]  product;
    logic [FP_EXP_W:0]     new_exponent;
    logic                  new_sign;

    modport master (
        output start, a, b,
        input  busy, done, product, new_exponent, new_sign
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, new_exponent, new_sign
    );

endinterface

// File: rtl/fp_mul_mant_seq_mult.sv
// Radix-2 shift-add significand multiplier datapath, one multiplier bit per
// clock. The controller loads operands, then steps W times.
//   clk, reset : clock, synchronous active-low reset
//   load       : latch operands, clear accumulator and counter
//   step       : perform one shift-add iteration
//   mcand_in   : multiplicand significand
//   mplier_in  : multiplier significand
//   acc_next   : accumulator value after the current iteration
//   last       : current iteration is the final one
module mant_seq_mult
    import fp_pkg::*;
#(
    parameter int W = FP_MANT_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   mcand_in,
    input  logic [W-1:0]   mplier_in,
    output logic [2*W-1:0] acc_next,
    output logic           last
);

    localparam int CNT_W = $clog2(W);

    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CNT_W-1:0] cnt;

    // Partial sums never exceed 2W bits, so the add cannot overflow.
    assign acc_next = mplier[0] ? acc + mcand : acc;
    assign last     = (cnt == CNT_W'(W - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{W{1'b0}}, mcand_in};
            mplier <= mplier_in;
            cnt    <= '0;
        end else if (step) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fp_mul_mant_seq.sv
// Sequential mantissa/exponent core of the FP multiply path. Produces the raw
// significand product, clamped biased exponent sum and result sign for the
// downstream normalize/round stage. Zero (or denormal) operands complete in a
// single cycle without entering RUN.
//   clk   : clock
//   reset : synchronous active-low reset
//   bus   : request/result bundle (slave side)
//
// state   | meaning
// --------+---------------------------------------------
// ST_IDLE | waiting for start; zero-path ops finish here
// ST_RUN  | shift-add iterations in progress (busy=1)
module fp_mul_mant_seq
    import fp_pkg::*;
#(
    parameter int MANT_W = FP_MANT_W,
    parameter int BIAS   = FP_BIAS
) (
    input  logic               clk,
    input  logic               reset,
    fp_mul_mant_seq_if.slave   bus
);

    localparam int SUM_W = FP_EXP_W + 2;
    localparam logic [SUM_W-1:0] BIAS_V = SUM_W'(BIAS);

    state_t state, state_nxt;

    logic                  load, step, finish, zero_op, last;
    logic                  zero_in;
    logic [2*MANT_W-1:0]   acc_next;
    logic [SUM_W-1:0]      exp_sum;
    logic [FP_EXP_W:0]     exp_calc, exp_q;
    logic                  sign_calc, sign_q;

    assign zero_in   = !fp_hidden(bus.a) || !fp_hidden(bus.b);
    assign exp_sum   = {2'b00, fp_exp(bus.a)} + {2'b00, fp_exp(bus.b)};
    assign exp_calc  = (exp_sum < BIAS_V) ? '0 : (FP_EXP_W+1)'(exp_sum - BIAS_V);
    assign sign_calc = fp_sign(bus.a) ^ fp_sign(bus.b);

    mant_seq_mult #(.W(MANT_W)) u_mult (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .mcand_in  (MANT_W'(fp_mant(bus.a))),
        .mplier_in (MANT_W'(fp_mant(bus.b))),
        .acc_next  (acc_next),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        zero_op   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (zero_in) begin
                        zero_op = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (last) begin
                    finish    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.busy = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.done         <= 1'b0;
            bus.product      <= '0;
            bus.new_exponent <= '0;
            bus.new_sign     <= 1'b0;
            exp_q            <= '0;
            sign_q           <= 1'b0;
        end else begin
            bus.done <= zero_op | finish;
            if (load) begin
                exp_q  <= exp_calc;
                sign_q <= sign_calc;
            end
            if (zero_op) begin
                bus.product      <= '0;
                bus.new_exponent <= '0;
                bus.new_sign     <= sign_calc;
            end else if (finish) begin
                // Final iteration's sum goes straight to the output register.
                bus.product      <= FP_PROD_W'({1'b0, acc_next, 2'b00});
                bus.new_exponent <= exp_q;
                bus.new_sign     <= sign_q;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_mant_seq.sv
module tb_fp_mul_mant_seq;

    typedef struct {
        logic [50:0] prod;
        logic [8:0]  ex;
        logic        sg;
        int          due;
        int          runlen;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   run_cnt = 0;
    exp_t sb[$];

    fp_mul_mant_seq_if bus();

    fp_mul_mant_seq dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Reference: plain arithmetic on the IEEE fields.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        int unsigned ea, eb, s;
        longint unsigned ma, mb, p;
        ea = x[30:23];
        eb = y[30:23];
        e.sg = x[31] ^ y[31];
        if (ea == 0 || eb == 0) begin
            e.prod   = '0;
            e.ex     = '0;
            e.runlen = 0;
        end else begin
            ma = (longint'(1) << 23) + longint'(x[22:0]);
            mb = (longint'(1) << 23) + longint'(y[22:0]);
            p  = ma * mb;
            e.prod = 51'(p << 2);
            s = ea + eb;
            e.ex = (s < 127) ? 9'd0 : 9'(s - 127);
            e.runlen = 24;
        end
        e.due = 0;
        return e;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            run_cnt = 0;
        end else begin
            if (bus.busy) run_cnt++;
            if (bus.done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 want no pending op (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("product", 64'(bus.product), 64'(e.prod));
                    chk("new_exponent", 64'(bus.new_exponent), 64'(e.ex));
                    chk("new_sign", 64'(bus.new_sign), 64'(e.sg));
                    chk("latency", 64'(cyc), 64'(e.due));
                    chk("busy_at_done", 64'(bus.busy), 64'd0);
                    chk("busy_cycles", 64'(run_cnt), 64'(e.runlen));
                end
                run_cnt = 0;
            end
        end
    end

    // Issue one op and wait for its done. back=1: issue in the current
    // (done) cycle; poke=1: pulse a stray start mid-RUN.
    task automatic run_op(input logic [31:0] oa, input logic [31:0] ob,
                          input bit back, input bit poke);
        exp_t e;
        bit got;
        if (!back) @(negedge clk);
        bus.a = oa;
        bus.b = ob;
        bus.start = 1'b1;
        e = model(oa, ob);
        e.due = cyc + 1 + e.runlen;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                got = 1;
                break;
            end
            if (poke && i == 5) begin
                bus.a = 32'h4049_0FDB;
                bus.b = 32'h4120_0000;
            end
            bus.start = poke && (i == 5);
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done want done within 40 cycles");
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_product", 64'(bus.product), 64'd0);
        chk("rst_exponent", 64'(bus.new_exponent), 64'd0);
        chk("rst_sign", 64'(bus.new_sign), 64'd0);
        rst = 1'b1;

        run_op(32'h3FC0_0000, 32'h4000_0000, 0, 0);
        chk("dir_1p5x2", 64'(bus.product), 64'h1_8000_0000_0000);
        run_op(32'hC000_0000, 32'h4040_0000, 0, 0);
        chk("dir_m2x3_exp", 64'(bus.new_exponent), 64'h081);
        run_op(32'h7F7F_FFFF, 32'h7F7F_FFFF, 0, 0);
        chk("dir_max_exp", 64'(bus.new_exponent), 64'h17D);
        run_op(32'h0000_0000, 32'hBF80_0000, 0, 0);
        chk("dir_zero_sign", 64'(bus.new_sign), 64'd1);
        run_op(32'h0080_0000, 32'h0080_0000, 0, 0);
        chk("dir_underflow_prod", 64'(bus.product), 64'h1_0000_0000_0000);

        // Stray start mid-RUN, then back-to-back on done, then hold check.
        run_op(32'h3FC0_0000, 32'h4000_0000, 0, 1);
        run_op(32'hC000_0000, 32'h4040_0000, 1, 0);
        run_op(32'h0000_0000, 32'h4040_0000, 1, 0);
        run_op(32'h3F80_0001, 32'h3FFF_FFFF, 1, 0);
        repeat (3) @(negedge clk);
        chk("hold_exponent", 64'(bus.new_exponent), 64'h07F);

        // Reset during RUN: no done, outputs return to reset values.
        @(negedge clk);
        bus.a = 32'h4049_0FDB;
        bus.b = 32'h4049_0FDB;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", 64'(bus.busy), 64'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_product", 64'(bus.product), 64'd0);
        chk("abort_exponent", 64'(bus.new_exponent), 64'd0);
        chk("abort_sign", 64'(bus.new_sign), 64'd0);
        repeat (30) @(negedge clk);

        run_op(32'hC0A0_0000, 32'hC0E0_0000, 0, 0);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 4) == 0) x[30:23] = 8'h00;
            if ($urandom_range(0, 6) == 0) y[30:23] = 8'h00;
            run_op(x, y, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
